// File: rtl/osc_tick_divider.sv
// Multi-channel programmable tick/PWM divider clocked by the on-chip oscillator.
// Period and duty are written into pending shadows and copied to the active pair together.
module osc_tick_divider #(
    parameter int NUM_CH         = 4,
    parameter int DIV_W          = 24,
    parameter int DEFAULT_PERIOD = 2625000,
    parameter int DEFAULT_DUTY   = 1312500,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic              wr_sel,
    input  logic [DIV_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] wave_out
);

    logic [DIV_W-1:0] pend_p     [NUM_CH];
    logic [DIV_W-1:0] pend_d     [NUM_CH];
    logic [DIV_W-1:0] act_p      [NUM_CH];
    logic [DIV_W-1:0] act_d      [NUM_CH];
    logic [DIV_W-1:0] cnt        [NUM_CH];
    logic [DIV_W-1:0] pend_p_nxt [NUM_CH];
    logic [DIV_W-1:0] pend_d_nxt [NUM_CH];
    logic [DIV_W-1:0] peff       [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic              wr_valid;

    assign wr_valid = wr_en && (int'(wr_ch) < NUM_CH);

    // Pending "next" values fold in a write on the same edge, so a load at
    // wrap (or while disabled) picks up that write too.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_p_nxt[i] = pend_p[i];
            pend_d_nxt[i] = pend_d[i];
            if (wr_valid && (int'(wr_ch) == i)) begin
                if (wr_sel) pend_d_nxt[i] = wr_data;
                else        pend_p_nxt[i] = wr_data;
            end
            peff[i] = (act_p[i] == '0) ? DIV_W'(1) : act_p[i];
            wrap[i] = ch_en[i] && (cnt[i] == peff[i] - DIV_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_p[i]   <= DIV_W'(DEFAULT_PERIOD);
                pend_d[i]   <= DIV_W'(DEFAULT_DUTY);
                act_p[i]    <= DIV_W'(DEFAULT_PERIOD);
                act_d[i]    <= DIV_W'(DEFAULT_DUTY);
                cnt[i]      <= '0;
                tick_out[i] <= 1'b0;
                wave_out[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_p[i] <= pend_p_nxt[i];
                pend_d[i] <= pend_d_nxt[i];
                if (!ch_en[i] || wrap[i]) begin
                    act_p[i] <= pend_p_nxt[i];
                    act_d[i] <= pend_d_nxt[i];
                end
                if (!ch_en[i]) begin
                    cnt[i]      <= '0;
                    tick_out[i] <= 1'b0;
                    wave_out[i] <= 1'b0;
                end else begin
                    cnt[i]      <= wrap[i] ? '0 : cnt[i] + DIV_W'(1);
                    tick_out[i] <= wrap[i];
                    wave_out[i] <= (cnt[i] < act_d[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_valid;
            wr_err <= wr_en && !wr_valid;
        end
    end

endmodule

// File: tb/tb_osc_tick_divider.sv
// Directed bench for osc_tick_divider: 3 channels with a short default period
// so that the error-channel index and the default rate are reachable quickly.
module tb_osc_tick_divider;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 24;
    localparam int DEF_P  = 10;
    localparam int DEF_D  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic              wr_sel;
    logic [DIV_W-1:0]  wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] wave_out;

    int vectors    = 0;
    int miscompares = 0;

    osc_tick_divider #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W),
        .DEFAULT_PERIOD(DEF_P), .DEFAULT_DUTY(DEF_D)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .ch_en(ch_en), .tick_out(tick_out), .wave_out(wave_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic sel, input int data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_sel  = sel;
        wr_data = DIV_W'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = '0; wr_en = 1'b0; wr_ch = '0; wr_sel = 1'b0; wr_data = '0;
        step();
        step();
        reset = 1'b0;
        vectors++;
        if (tick_out !== 3'b000) begin miscompares++; $display("FAIL reset_tick: got %b expected 000", tick_out); end
        vectors++;
        if (wave_out !== 3'b000) begin miscompares++; $display("FAIL reset_wave: got %b expected 000", wave_out); end
        vectors++;
        if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", wr_ack); end
        vectors++;
        if (wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", wr_err); end
    endtask

    task automatic test_default_rate();
        logic [NUM_CH-1:0] ew, et;
        ch_en = 3'b111;
        for (int i = 0; i < 25; i++) begin
            step();
            ew = (i % DEF_P < DEF_D) ? 3'b111 : 3'b000;
            et = (i % DEF_P == DEF_P - 1) ? 3'b111 : 3'b000;
            vectors++;
            if (wave_out !== ew || tick_out !== et) begin
                miscompares++;
                $display("FAIL default_rate[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out, tick_out, ew, et);
            end
        end
    endtask

    task automatic test_p4_d1();
        int c;
        ch_en[0] = 1'b0;
        step();
        vectors++;
        if (wave_out[0] !== 1'b0 || tick_out[0] !== 1'b0) begin
            miscompares++; $display("FAIL p4d1_disable: got wave=%b tick=%b expected 0 0", wave_out[0], tick_out[0]);
        end
        do_write(2'd0, 1'b0, 4);
        vectors++;
        if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL p4d1_ack: got %b expected 1", wr_ack); end
        do_write(2'd0, 1'b1, 1);
        ch_en[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            c = i % 4;
            vectors++;
            if (wave_out[0] !== (c < 1) || tick_out[0] !== (c == 3)) begin
                miscompares++;
                $display("FAIL p4d1[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out[0], tick_out[0], (c < 1), (c == 3));
            end
        end
    endtask

    task automatic test_shadow_load();
        logic ew, et;
        int c;
        ch_en[1] = 1'b0;
        step();
        do_write(2'd1, 1'b0, 8);
        do_write(2'd1, 1'b1, 4);
        ch_en[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                wr_en = 1'b1; wr_ch = 2'd1; wr_sel = 1'b0; wr_data = DIV_W'(4);
            end
            step();
            wr_en = 1'b0;
            if (i < 8) begin
                ew = (i < 4);
                et = (i == 7);
            end else begin
                c  = (i - 8) % 4;
                ew = 1'b1;
                et = (c == 3);
            end
            vectors++;
            if (wave_out[1] !== ew || tick_out[1] !== et) begin
                miscompares++;
                $display("FAIL shadow_load[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out[1], tick_out[1], ew, et);
            end
        end
    endtask

    task automatic test_duty_bounds();
        ch_en[2] = 1'b0;
        step();
        do_write(2'd2, 1'b0, 5);
        do_write(2'd2, 1'b1, 0);
        ch_en[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (wave_out[2] !== 1'b0 || tick_out[2] !== (i % 5 == 4)) begin
                miscompares++;
                $display("FAIL duty_zero[%0d]: got wave=%b tick=%b expected wave=0 tick=%b", i, wave_out[2], tick_out[2], (i % 5 == 4));
            end
        end
        ch_en[2] = 1'b0;
        step();
        do_write(2'd2, 1'b1, 9);
        ch_en[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (wave_out[2] !== 1'b1 || tick_out[2] !== (i % 5 == 4)) begin
                miscompares++;
                $display("FAIL duty_full[%0d]: got wave=%b tick=%b expected wave=1 tick=%b", i, wave_out[2], tick_out[2], (i % 5 == 4));
            end
        end
        ch_en[2] = 1'b0;
        step();
        do_write(2'd2, 1'b0, 0);
        ch_en[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (wave_out[2] !== 1'b1 || tick_out[2] !== 1'b1) begin
                miscompares++;
                $display("FAIL period_zero[%0d]: got wave=%b tick=%b expected wave=1 tick=1", i, wave_out[2], tick_out[2]);
            end
        end
    endtask

    task automatic test_write_err();
        int c;
        ch_en[0] = 1'b0;
        step();
        wr_en = 1'b1; wr_ch = 2'd3; wr_sel = 1'b0; wr_data = DIV_W'(1);
        ch_en[0] = 1'b1;
        step();
        wr_en = 1'b0;
        vectors++;
        if (wr_err !== 1'b1 || wr_ack !== 1'b0) begin
            miscompares++; $display("FAIL bad_ch_pulse: got err=%b ack=%b expected err=1 ack=0", wr_err, wr_ack);
        end
        vectors++;
        if (wave_out[0] !== 1'b1 || tick_out[0] !== 1'b0) begin
            miscompares++; $display("FAIL bad_ch_c0: got wave=%b tick=%b expected wave=1 tick=0", wave_out[0], tick_out[0]);
        end
        for (int i = 1; i < 12; i++) begin
            if (i == 1) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_sel = 1'b1; wr_data = DIV_W'(9);
            end
            step();
            wr_en = 1'b0;
            if (i == 1) begin
                vectors++;
                if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
                    miscompares++; $display("FAIL good_ch_pulse: got ack=%b err=%b expected ack=1 err=0", wr_ack, wr_err);
                end
            end
            if (i == 2) begin
                vectors++;
                if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin
                    miscompares++; $display("FAIL pulse_width: got ack=%b err=%b expected ack=0 err=0", wr_ack, wr_err);
                end
            end
            c = i % 4;
            vectors++;
            if (wave_out[0] !== (c < 1) || tick_out[0] !== (c == 3)) begin
                miscompares++;
                $display("FAIL bad_ch_no_change[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out[0], tick_out[0], (c < 1), (c == 3));
            end
        end
    endtask

    task automatic test_reset_and_disable();
        logic [NUM_CH-1:0] ew, et;
        int c0, c12;
        do_write(2'd1, 1'b0, 6);
        reset = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_sel = 1'b0; wr_data = DIV_W'(7);
        step();
        wr_en = 1'b0;
        reset = 1'b0;
        vectors++;
        if (tick_out !== 3'b000 || wave_out !== 3'b000 || wr_ack !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset: got tick=%b wave=%b ack=%b expected 000 000 0", tick_out, wave_out, wr_ack);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            ew = (i % DEF_P < DEF_D) ? 3'b111 : 3'b000;
            et = (i % DEF_P == DEF_P - 1) ? 3'b111 : 3'b000;
            vectors++;
            if (wave_out !== ew || tick_out !== et) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out, tick_out, ew, et);
            end
        end
        ch_en = 3'b110;
        for (int i = 14; i < 16; i++) begin
            step();
            ew = (i % DEF_P < DEF_D) ? 3'b110 : 3'b000;
            et = 3'b000;
            vectors++;
            if (wave_out !== ew || tick_out !== et) begin
                miscompares++;
                $display("FAIL drop_en[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out, tick_out, ew, et);
            end
        end
        ch_en = 3'b111;
        for (int i = 0; i < 12; i++) begin
            step();
            c0  = i % DEF_P;
            c12 = (16 + i) % DEF_P;
            ew = {(c12 < DEF_D), (c12 < DEF_D), (c0 < DEF_D)};
            et = {(c12 == DEF_P - 1), (c12 == DEF_P - 1), (c0 == DEF_P - 1)};
            vectors++;
            if (wave_out !== ew || tick_out !== et) begin
                miscompares++;
                $display("FAIL re_enable[%0d]: got wave=%b tick=%b expected wave=%b tick=%b", i, wave_out, tick_out, ew, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_p4_d1();
        test_shadow_load();
        test_duty_bounds();
        test_write_err();
        test_reset_and_disable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
